// File: rtl/alarm_sched_if.sv
// Bus bundle for alarm_sched: time ticks, slot config, user buttons and ring outputs.
// ALARM_MISSED_CNT_EN adds missed_clr / missed_cnt.
interface alarm_sched_if;
  logic        sec_tick;
  logic        min_tick;
  logic [15:0] cur_time;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_time;
  logic        cfg_en;
  logic        ack;
  logic        snooze;
  logic        ring_load;
  logic [15:0] ring_data;
  logic        alarm_on;
  logic [2:0]  active_slot;
  logic [1:0]  snooze_cnt;
`ifdef ALARM_MISSED_CNT_EN
  logic        missed_clr;
  logic [7:0]  missed_cnt;
`endif

  modport master (
    output sec_tick, min_tick, cur_time, cfg_we, cfg_addr, cfg_time, cfg_en, ack, snooze,
`ifdef ALARM_MISSED_CNT_EN
    output missed_clr,
    input  missed_cnt,
`endif
    input  ring_load, ring_data, alarm_on, active_slot, snooze_cnt
  );

  modport slave (
    input  sec_tick, min_tick, cur_time, cfg_we, cfg_addr, cfg_time, cfg_en, ack, snooze,
`ifdef ALARM_MISSED_CNT_EN
    input  missed_clr,
    output missed_cnt,
`endif
    output ring_load, ring_data, alarm_on, active_slot, snooze_cnt
  );
endinterface

// File: rtl/alarm_sched.sv
// Alarm scheduler: per-minute slot scan, ring/snooze/timeout sequencing.
// ALARM_MISSED_CNT_EN adds a saturating count of unanswered (timed-out) alarms.
module alarm_sched #(
  parameter int NUM_SLOTS  = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic         clk,
  input  logic         rst,
  alarm_sched_if.slave bus
);
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(RING_SEC + 1);

  typedef enum logic [1:0] {IDLE, SCAN, RING, SNOOZE} state_t;

  state_t                 r_state;
  logic [15:0]            r_slot_time [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   r_slot_en;
  logic [2:0]             r_idx;
  logic [15:0]            r_scan_time;
  logic [15:0]            r_snz_time;
  logic [CW-1:0]          r_sec_cnt;
  logic                   r_ring_load;
  logic [15:0]            r_ring_data;
  logic                   r_alarm_on;
  logic [2:0]             r_active;
  logic [1:0]             r_snz_cnt;

  // BCD HHMM plus a fixed minute offset, wrapping at 24:00
  function automatic logic [15:0] bcd_add_min(input logic [15:0] t);
    int m, h;
    m = int'(t[7:4]) * 10 + int'(t[3:0]) + SNOOZE_MIN;
    h = int'(t[15:12]) * 10 + int'(t[11:8]);
    if (m >= 60) begin
      m = m - 60;
      h = h + 1;
    end
    if (h >= 24) h = h - 24;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  wire [IW-1:0] w_sidx    = r_idx[IW-1:0];
  wire          w_hit     = r_slot_en[w_sidx] && (r_slot_time[w_sidx] == r_scan_time);
  wire          w_last    = (r_idx == 3'(NUM_SLOTS - 1));
  wire [15:0]   w_snz_nxt = bcd_add_min(bus.cur_time);
  wire          w_snz_ok  = bus.snooze && (r_snz_cnt < 2'(MAX_SNOOZE));
  wire          w_timeout = (r_state == RING) && !bus.ack && !w_snz_ok && bus.sec_tick &&
                            (r_sec_cnt == CW'(RING_SEC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slot_time[i] <= '0;
      r_slot_en <= '0;
    end else if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_SLOTS)) begin
      r_slot_time[bus.cfg_addr[IW-1:0]] <= bus.cfg_time;
      r_slot_en[bus.cfg_addr[IW-1:0]]   <= bus.cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_scan_time <= '0;
      r_snz_time  <= '0;
      r_sec_cnt   <= '0;
      r_ring_load <= 1'b0;
      r_ring_data <= '0;
      r_alarm_on  <= 1'b0;
      r_active    <= '0;
      r_snz_cnt   <= '0;
    end else begin
      r_ring_load <= 1'b0;
      case (r_state)
        IDLE: if (bus.min_tick) begin
          r_scan_time <= bus.cur_time;
          r_idx       <= '0;
          r_state     <= SCAN;
        end
        SCAN: begin
          if (w_hit) begin
            r_state     <= RING;
            r_active    <= r_idx;
            r_snz_cnt   <= '0;
            r_ring_load <= 1'b1;
            r_ring_data <= r_slot_time[w_sidx];
            r_alarm_on  <= 1'b1;
            r_sec_cnt   <= '0;
          end else if (w_last) begin
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        RING: begin
          if (bus.ack || w_timeout) begin
            r_state    <= IDLE;
            r_alarm_on <= 1'b0;
            r_snz_cnt  <= '0;
            r_active   <= '0;
          end else if (w_snz_ok) begin
            r_state     <= SNOOZE;
            r_snz_cnt   <= r_snz_cnt + 2'd1;
            r_snz_time  <= w_snz_nxt;
            r_ring_load <= 1'b1;
            r_ring_data <= w_snz_nxt;
            r_alarm_on  <= 1'b0;
          end else if (bus.sec_tick) begin
            r_sec_cnt <= r_sec_cnt + CW'(1);
          end
        end
        SNOOZE: begin
          if (bus.ack) begin
            r_state   <= IDLE;
            r_snz_cnt <= '0;
            r_active  <= '0;
          end else if (bus.min_tick && (bus.cur_time == r_snz_time)) begin
            r_state    <= RING;
            r_alarm_on <= 1'b1;
            r_sec_cnt  <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ring_load   = r_ring_load;
  assign bus.ring_data   = r_ring_data;
  assign bus.alarm_on    = r_alarm_on;
  assign bus.active_slot = r_active;
  assign bus.snooze_cnt  = r_snz_cnt;

`ifdef ALARM_MISSED_CNT_EN
  logic [7:0] r_missed;
  always_ff @(posedge clk) begin
    if (rst || bus.missed_clr) r_missed <= '0;
    else if (w_timeout && (r_missed != 8'hFF)) r_missed <= r_missed + 8'd1;
  end
  assign bus.missed_cnt = r_missed;
`endif
endmodule

// File: tb/tb_alarm_sched.sv
// Directed bench for alarm_sched: scan priority, snooze with BCD wrap, timeout, reset.
module tb_alarm_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alarm_sched_if bus();
  alarm_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [15:0] t, input logic en);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_time = t; bus.cfg_en = en;
    cyc();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_min(input logic [15:0] t);
    bus.cur_time = t; bus.min_tick = 1'b1;
    cyc();
    bus.min_tick = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1; cyc(); bus.ack = 1'b0;
  endtask

  task automatic pulse_snooze();
    bus.snooze = 1'b1; cyc(); bus.snooze = 1'b0;
  endtask

  task automatic wait_load(input int maxc, output bit got);
    got = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      cyc();
      if (bus.ring_load) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc();
    total++;
    if ({bus.ring_load, bus.ring_data, bus.alarm_on, bus.active_slot, bus.snooze_cnt} !== 23'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {bus.ring_load, bus.ring_data, bus.alarm_on, bus.active_slot, bus.snooze_cnt});
    end
`ifdef ALARM_MISSED_CNT_EN
    total++;
    if (bus.missed_cnt !== 8'd0) begin bad++; $display("FAIL reset_missed got=%0d want=0", bus.missed_cnt); end
`endif
    rst = 1'b0; cyc();
  endtask

  task automatic test_basic();
    bit got;
    cfg_wr(3'd0, 16'h1234, 1'b1);
    pulse_min(16'h1234);
    wait_load(4, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL basic_load got=%0d want=1", got); end
    total++;
    if (bus.ring_data !== 16'h1234) begin bad++; $display("FAIL basic_data got=%h want=1234", bus.ring_data); end
    total++;
    if (bus.alarm_on !== 1'b1 || bus.active_slot !== 3'd0) begin
      bad++; $display("FAIL basic_ring on=%0d slot=%0d want on=1 slot=0", bus.alarm_on, bus.active_slot);
    end
    cyc();
    total++;
    if (bus.ring_load !== 1'b0) begin bad++; $display("FAIL basic_one_shot got=%0d want=0", bus.ring_load); end
    pulse_ack();
    total++;
    if (bus.alarm_on !== 1'b0 || bus.snooze_cnt !== 2'd0) begin
      bad++; $display("FAIL basic_ack on=%0d scnt=%0d want 0/0", bus.alarm_on, bus.snooze_cnt);
    end
    total++;
    if (bus.ring_data !== 16'h1234) begin bad++; $display("FAIL basic_hold got=%h want=1234", bus.ring_data); end
  endtask

  task automatic test_cfg_oob();
    bit got;
    cfg_wr(3'd4, 16'h0900, 1'b1);
    pulse_min(16'h0900);
    wait_load(8, got);
    total++;
    if (got !== 1'b0 || bus.alarm_on !== 1'b0) begin
      bad++; $display("FAIL cfg_oob load=%0d on=%0d want 0/0", got, bus.alarm_on);
    end
  endtask

  task automatic test_priority();
    bit got;
    cfg_wr(3'd1, 16'h0700, 1'b0);
    cfg_wr(3'd2, 16'h0700, 1'b1);
    pulse_min(16'h0700);
    wait_load(6, got);
    total++;
    if (got !== 1'b1 || bus.active_slot !== 3'd2) begin
      bad++; $display("FAIL prio_slot2 load=%0d slot=%0d want 1/2", got, bus.active_slot);
    end
    pulse_ack();
    cfg_wr(3'd1, 16'h0700, 1'b1);
    pulse_min(16'h0700);
    wait_load(6, got);
    total++;
    if (got !== 1'b1 || bus.active_slot !== 3'd1) begin
      bad++; $display("FAIL prio_slot1 load=%0d slot=%0d want 1/1", got, bus.active_slot);
    end
    pulse_ack();
    cfg_wr(3'd1, 16'h0700, 1'b0);
    cfg_wr(3'd2, 16'h0700, 1'b0);
  endtask

  task automatic test_snooze();
    bit got;
    cfg_wr(3'd3, 16'h2358, 1'b1);
    pulse_min(16'h2358);
    wait_load(6, got);
    total++;
    if (got !== 1'b1 || bus.active_slot !== 3'd3) begin
      bad++; $display("FAIL snz_ring load=%0d slot=%0d want 1/3", got, bus.active_slot);
    end
    pulse_snooze();
    total++;
    if (bus.ring_load !== 1'b1 || bus.ring_data !== 16'h0003) begin
      bad++; $display("FAIL snz_wrap load=%0d data=%h want 1/0003", bus.ring_load, bus.ring_data);
    end
    total++;
    if (bus.alarm_on !== 1'b0 || bus.snooze_cnt !== 2'd1) begin
      bad++; $display("FAIL snz_state on=%0d scnt=%0d want 0/1", bus.alarm_on, bus.snooze_cnt);
    end
    pulse_min(16'h0002);
    total++;
    if (bus.alarm_on !== 1'b0) begin bad++; $display("FAIL snz_early got=%0d want=0", bus.alarm_on); end
    pulse_min(16'h0003);
    total++;
    if (bus.alarm_on !== 1'b1 || bus.ring_load !== 1'b0) begin
      bad++; $display("FAIL snz_rering on=%0d load=%0d want 1/0", bus.alarm_on, bus.ring_load);
    end
    pulse_snooze();
    total++;
    if (bus.ring_data !== 16'h0008 || bus.snooze_cnt !== 2'd2) begin
      bad++; $display("FAIL snz_second data=%h scnt=%0d want 0008/2", bus.ring_data, bus.snooze_cnt);
    end
    pulse_min(16'h0008);
    pulse_snooze();
    total++;
    if (bus.ring_data !== 16'h0013 || bus.snooze_cnt !== 2'd3) begin
      bad++; $display("FAIL snz_third data=%h scnt=%0d want 0013/3", bus.ring_data, bus.snooze_cnt);
    end
    pulse_min(16'h0013);
    pulse_snooze();
    total++;
    if (bus.alarm_on !== 1'b1 || bus.snooze_cnt !== 2'd3 || bus.ring_load !== 1'b0) begin
      bad++; $display("FAIL snz_limit on=%0d scnt=%0d load=%0d want 1/3/0",
        bus.alarm_on, bus.snooze_cnt, bus.ring_load);
    end
    pulse_ack();
    total++;
    if (bus.alarm_on !== 1'b0 || bus.snooze_cnt !== 2'd0) begin
      bad++; $display("FAIL snz_ack on=%0d scnt=%0d want 0/0", bus.alarm_on, bus.snooze_cnt);
    end
    cfg_wr(3'd3, 16'h2358, 1'b0);
  endtask

  task automatic test_timeout();
    bit got;
    pulse_min(16'h1234);
    wait_load(4, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL to_ring got=%0d want=1", got); end
    for (int s = 0; s < 59; s++) begin
      bus.sec_tick = 1'b1; cyc(); bus.sec_tick = 1'b0; cyc();
    end
    total++;
    if (bus.alarm_on !== 1'b1) begin bad++; $display("FAIL to_59 got=%0d want=1", bus.alarm_on); end
    bus.sec_tick = 1'b1; cyc(); bus.sec_tick = 1'b0;
    total++;
    if (bus.alarm_on !== 1'b0) begin bad++; $display("FAIL to_60 got=%0d want=0", bus.alarm_on); end
    pulse_snooze();
    total++;
    if (bus.ring_load !== 1'b0 || bus.alarm_on !== 1'b0) begin
      bad++; $display("FAIL to_idle_snz load=%0d on=%0d want 0/0", bus.ring_load, bus.alarm_on);
    end
`ifdef ALARM_MISSED_CNT_EN
    total++;
    if (bus.missed_cnt !== 8'd1) begin bad++; $display("FAIL missed_cnt got=%0d want=1", bus.missed_cnt); end
    bus.missed_clr = 1'b1; cyc(); bus.missed_clr = 1'b0;
    total++;
    if (bus.missed_cnt !== 8'd0) begin bad++; $display("FAIL missed_clr got=%0d want=0", bus.missed_cnt); end
`endif
  endtask

  task automatic test_reset_mid_ring();
    bit got;
    cfg_wr(3'd2, 16'h1500, 1'b1);
    pulse_min(16'h1500);
    wait_load(6, got);
    total++;
    if (got !== 1'b1 || bus.active_slot !== 3'd2) begin
      bad++; $display("FAIL rst_pre load=%0d slot=%0d want 1/2", got, bus.active_slot);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    total++;
    if ({bus.ring_load, bus.ring_data, bus.alarm_on, bus.active_slot, bus.snooze_cnt} !== 23'd0) begin
      bad++; $display("FAIL rst_mid got=%h want=0",
        {bus.ring_load, bus.ring_data, bus.alarm_on, bus.active_slot, bus.snooze_cnt});
    end
    pulse_min(16'h1500);
    wait_load(8, got);
    total++;
    if (got !== 1'b0 || bus.alarm_on !== 1'b0) begin
      bad++; $display("FAIL rst_cleared load=%0d on=%0d want 0/0", got, bus.alarm_on);
    end
  endtask

  initial begin
    bus.sec_tick = 1'b0; bus.min_tick = 1'b0; bus.cur_time = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_time = '0; bus.cfg_en = 1'b0;
    bus.ack = 1'b0; bus.snooze = 1'b0;
`ifdef ALARM_MISSED_CNT_EN
    bus.missed_clr = 1'b0;
`endif
    test_reset();
    test_basic();
    test_cfg_oob();
    test_priority();
    test_snooze();
    test_timeout();
    test_reset_mid_ring();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_sched.md
Name: alarm_sched

Overview:
- Alarm scheduler and sequencer for the digital clock's ring path.
- Holds NUM_SLOTS programmable alarm times (BCD HHMM) and checks them against the current time once per minute.
- Drives the ring datapath (load strobe plus time word) and the buzzer enable, and manages acknowledge, snooze and ring timeout.

Parameters:
- NUM_SLOTS, 4, number of alarm slots (2..8).
- RING_SEC, 60, seconds the buzzer stays on before auto-timeout.
- SNOOZE_MIN, 5, snooze delay in minutes (1..59).
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- sec_tick  in  1  one-cycle pulse once per second
- min_tick  in  1  one-cycle pulse at each minute rollover; cur_time is already updated on this cycle
- cur_time  in  16  current time, BCD HHMM (e.g. 16'h1234 = 12:34)
- cfg_we  in  1  write strobe for the slot config
- cfg_addr  in  3  slot index; writes with cfg_addr >= NUM_SLOTS are ignored
- cfg_time  in  16  BCD HHMM alarm time
- cfg_en  in  1  slot enable bit
- ack  in  1  stop-alarm pulse
- snooze  in  1  snooze request pulse
- ring_load  out  1  one-cycle strobe to the ring datapath
- ring_data  out  16  time word presented with ring_load
- alarm_on  out  1  buzzer enable
- active_slot  out  3  slot currently ringing or snoozed
- snooze_cnt  out  2  snoozes used in the current event

Behaviour:
- Reset: all slots cleared (time 16'h0000, disabled), FSM to IDLE. All outputs are 0.
- Config writes:
  - Take effect the next cycle.
  - Are allowed in any state.
  - A write to the active slot does not affect the event in progress.
- FSM states: IDLE, SCAN, RING, SNOOZE.
- IDLE:
  - On min_tick, latch cur_time into scan_time, then go to SCAN with idx=0.
- SCAN:
  - Checks one slot per cycle; takes NUM_SLOTS cycles.
  - A hit is slot enabled AND slot time == scan_time.
  - The lowest-index hit wins.
  - On hit: go to RING, set active_slot=idx, snooze_cnt=0. In the same cycle, pulse ring_load=1 with ring_data=slot time.
  - No hit after the last slot: go to IDLE.
  - A min_tick arriving during SCAN is ignored. This is legal because NUM_SLOTS is much smaller than the tick spacing.
- RING:
  - alarm_on=1; a second counter is cleared on entry.
  - If ack and snooze arrive in the same cycle, ack has priority.
  - ack: go to IDLE, alarm_on=0 on the next cycle, snooze_cnt=0.
  - snooze with snooze_cnt < MAX_SNOOZE:
    - Go to SNOOZE and increment snooze_cnt.
    - snooze_time = cur_time + SNOOZE_MIN, computed in BCD. Minutes carry into hours; 23:59 wraps to 00:xx.
    - Pulse ring_load with ring_data=snooze_time.
  - snooze with snooze_cnt == MAX_SNOOZE: ignored; ringing continues.
  - When the counter reaches RING_SEC sec_ticks: timeout, go to IDLE.
- SNOOZE:
  - alarm_on=0.
  - On min_tick with cur_time == snooze_time: go to RING. Do not pulse ring_load; the second counter restarts.
  - ack: cancel and go to IDLE.
  - Slot scanning is suspended while in RING or SNOOZE. Other alarms falling in that window are dropped.
- ring_load is high for exactly one cycle per load event.
- ring_data holds its last value between events.
- Reset mid-RING or mid-SNOOZE: IDLE next cycle, alarm_on=0, slot config cleared.

Optional Feature:
- Macro name: ALARM_MISSED_CNT_EN.
- With it defined:
  - Adds output missed_cnt[7:0], counting RING timeouts. It saturates at 8'hFF and is cleared by reset.
  - Adds input missed_clr, which clears missed_cnt. If missed_clr coincides with a timeout, the clear wins.
- Without it: no extra ports or logic. A timeout only returns the FSM to IDLE.

Test Plan:
- Slot0=16'h1234 enabled. Drive min_tick with cur_time=16'h1234 -> ring_load pulse with ring_data=16'h1234 within 1..4 cycles. alarm_on=1, active_slot=0.
- Slots 1 and 2 both 16'h0700 enabled, slot1 disabled, tick at 07:00 -> active_slot=2. Then enable slot1 and repeat -> active_slot=1.
- Ringing at 23:58, pulse snooze -> ring_data=16'h0003, alarm_on=0, snooze_cnt=1. Tick at 16'h0003 -> alarm_on=1 again.
- Snooze 3 times, then a 4th snooze pulse -> ignored, alarm_on stays 1, snooze_cnt=3. ack -> alarm_on=0, snooze_cnt=0.
- No ack, 60 sec_ticks -> alarm_on=0 in IDLE. With ALARM_MISSED_CNT_EN defined, missed_cnt=1.
- Assert rst while ringing -> all outputs 0 next cycle. A min_tick at the old alarm time -> no ring, since slots are cleared.
